// File: rtl/ysyx_23060208_axi_sram_slv.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_axi_sram_slv
//
// Purpose
//   Single-beat AXI4 slave that fronts a 64-bit wide on-chip SRAM.
//   The read and write channels are served by two independent FSMs, so a
//   read and a write can be in flight at the same time. Each response
//   appears after a fixed wait of RESP_LAT cycles.
//   Bursts (awlen/arlen != 0) are not supported. They are answered with
//   SLVERR and never touch the array. Addresses outside
//   [BASE_ADDR, BASE_ADDR + 8*MEM_DEPTH) are answered with DECERR.
//   awsize/arsize/awburst/arburst are ignored. Byte selection comes from
//   wstrb only, and reads always return the full aligned word.
//
// Parameters
//   BASE_ADDR : byte address of memory word 0
//   MEM_DEPTH : number of 64-bit words (power of two, >= 2)
//   RESP_LAT  : response wait in cycles (>= 1)
//
// Optional feature (macro AXI_SLV_RAND_DELAY_EN)
//   When defined, each wait length is lfsr[1:0]+1 cycles (1..4), sampled
//   when the FSM enters its wait state. The LFSR is 4 bits wide with
//   polynomial x^4+x^3+1, is reset to 4'b1001 and advances every cycle.
//   When undefined, each wait lasts exactly RESP_LAT cycles.
//
// Ports
//   clock, reset                       : clock, synchronous active-high reset
//   AW : i_awvalid o_awready i_awaddr i_awid i_awlen i_awsize i_awburst
//   W  : i_wvalid  o_wready  i_wdata  i_wstrb i_wlast
//   B  : o_bvalid  i_bready  o_bresp  o_bid
//   AR : i_arvalid o_arready i_araddr i_arid i_arlen i_arsize i_arburst
//   R  : o_rvalid  i_rready  o_rdata  o_rresp o_rlast o_rid
// ---------------------------------------------------------------------------
module ysyx_23060208_axi_sram_slv #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_DEPTH = 1024,
    parameter int          RESP_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    // write address
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_awaddr,
    input  logic [3:0]  i_awid,
    input  logic [7:0]  i_awlen,
    input  logic [2:0]  i_awsize,
    input  logic [1:0]  i_awburst,
    // write data
    input  logic        i_wvalid,
    output logic        o_wready,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_wstrb,
    input  logic        i_wlast,
    // write response
    output logic        o_bvalid,
    input  logic        i_bready,
    output logic [1:0]  o_bresp,
    output logic [3:0]  o_bid,
    // read address
    input  logic        i_arvalid,
    output logic        o_arready,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arid,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic [1:0]  i_arburst,
    // read data
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [63:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rlast,
    output logic [3:0]  o_rid
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 3;
    localparam logic [7:0]  LAT_M1    = 8'(RESP_LAT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP}         r_state_t;

    // -----------------------------------------------------------------------
    // Address decode (combinational, from the live AW/AR address)
    // -----------------------------------------------------------------------
    logic [31:0]      w_aw_off;
    logic [31:0]      w_ar_off;
    logic             w_aw_in_range;
    logic             w_ar_in_range;
    logic [IDX_W-1:0] w_aw_idx;
    logic [IDX_W-1:0] w_ar_idx;

    assign w_aw_off      = i_awaddr - BASE_ADDR;
    assign w_ar_off      = i_araddr - BASE_ADDR;
    // The extra top bit keeps the upper bound exact even when
    // BASE_ADDR + 8*MEM_DEPTH wraps past 2^32.
    assign w_aw_in_range = (i_awaddr >= BASE_ADDR) && ({1'b0, w_aw_off} < MEM_BYTES);
    assign w_ar_in_range = (i_araddr >= BASE_ADDR) && ({1'b0, w_ar_off} < MEM_BYTES);
    assign w_aw_idx      = w_aw_off[IDX_W+2:3];
    assign w_ar_idx      = w_ar_off[IDX_W+2:3];

    // Size and burst type are ignored by design.
    logic w_unused;
    assign w_unused = ^{i_awsize, i_awburst, i_arsize, i_arburst};

    // -----------------------------------------------------------------------
    // Wait-length source: fixed, or a free-running LFSR
    // -----------------------------------------------------------------------
    logic [7:0] w_lat_load;   // cycles to wait, minus one

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [3:0] r_lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= 4'b1001;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    assign w_lat_load = {6'd0, r_lfsr[1:0]};
`else
    assign w_lat_load = LAT_M1;
`endif

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    w_state_t         r_wstate;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic [3:0]       r_bid;
    logic [IDX_W-1:0] r_widx;
    logic             r_wok;      // this transaction may write the array
    logic             r_wburst;   // awlen != 0: drain beats until wlast
    logic [7:0]       r_wcnt;
    logic             w_wr_en;

    assign w_wr_en = r_wready && i_wvalid && r_wok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= 4'd0;
            r_widx    <= '0;
            r_wok     <= 1'b0;
            r_wburst  <= 1'b0;
            r_wcnt    <= 8'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (i_awvalid) begin
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= i_awid;
                        r_widx    <= w_aw_idx;
                        r_wburst  <= (i_awlen != 8'd0);
                        r_wok     <= w_aw_in_range && (i_awlen == 8'd0);
                        // DECERR takes priority over SLVERR.
                        if (!w_aw_in_range) begin
                            r_bresp <= RESP_DECERR;
                        end else if (i_awlen != 8'd0) begin
                            r_bresp <= RESP_SLVERR;
                        end else begin
                            r_bresp <= RESP_OKAY;
                        end
                    end
                end
                W_DATA: begin
                    // A single-beat write finishes on its one beat. A burst
                    // finishes on the beat that carries wlast.
                    if (i_wvalid && (!r_wburst || i_wlast)) begin
                        r_wstate <= W_WAIT;
                        r_wready <= 1'b0;
                        r_wcnt   <= w_lat_load;
                    end
                end
                W_WAIT: begin
                    if (r_wcnt == 8'd0) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 8'd1;
                    end
                end
                W_RESP: begin
                    if (i_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_bid     = r_bid;

    // -----------------------------------------------------------------------
    // Read FSM
    // -----------------------------------------------------------------------
    r_state_t         r_rstate;
    logic             r_arready;
    logic             r_rvalid;
    logic             r_rlast;
    logic [1:0]       r_rresp;
    logic [1:0]       r_rresp_pend;
    logic [3:0]       r_rid;
    logic [IDX_W-1:0] r_ridx;
    logic             r_rok;
    logic             r_rdata_ok;   // gates the RAM output register onto rdata
    logic [7:0]       r_rcnt;
    logic             w_rd_en;
    logic [63:0]      w_rd_word;

    // The RAM is read on the same edge that moves R_WAIT to R_RESP.
    assign w_rd_en = (r_rstate == R_WAIT) && (r_rcnt == 8'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate     <= R_IDLE;
            r_arready    <= 1'b1;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_rresp      <= RESP_OKAY;
            r_rresp_pend <= RESP_OKAY;
            r_rid        <= 4'd0;
            r_ridx       <= '0;
            r_rok        <= 1'b0;
            r_rdata_ok   <= 1'b0;
            r_rcnt       <= 8'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (i_arvalid) begin
                        r_rstate  <= R_WAIT;
                        r_arready <= 1'b0;
                        r_rid     <= i_arid;
                        r_ridx    <= w_ar_idx;
                        r_rok     <= w_ar_in_range && (i_arlen == 8'd0);
                        r_rcnt    <= w_lat_load;
                        if (!w_ar_in_range) begin
                            r_rresp_pend <= RESP_DECERR;
                        end else if (i_arlen != 8'd0) begin
                            r_rresp_pend <= RESP_SLVERR;
                        end else begin
                            r_rresp_pend <= RESP_OKAY;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_rcnt == 8'd0) begin
                        r_rstate   <= R_RESP;
                        r_rvalid   <= 1'b1;
                        r_rlast    <= 1'b1;
                        r_rresp    <= r_rresp_pend;
                        r_rdata_ok <= r_rok;
                    end else begin
                        r_rcnt <= r_rcnt - 8'd1;
                    end
                end
                R_RESP: begin
                    if (i_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rlast   = r_rlast;
    assign o_rresp   = r_rresp;
    assign o_rid     = r_rid;
    // Error responses and the post-reset state carry zero data.
    assign o_rdata   = r_rdata_ok ? w_rd_word : 64'd0;

    // -----------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane, each with a registered read port.
    // The RAMs are not reset, so their contents survive reset. A write and a
    // read of the same word on the same edge return the old data, because
    // the non-blocking write lands after the read samples.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] r_mem [MEM_DEPTH];
        logic [7:0] r_rd_byte;

        always_ff @(posedge clock) begin
            if (w_wr_en && i_wstrb[gi]) begin
                r_mem[r_widx] <= i_wdata[8*gi +: 8];
            end
            if (w_rd_en) begin
                r_rd_byte <= r_mem[r_ridx];
            end
        end

        assign w_rd_word[8*gi +: 8] = r_rd_byte;
    end

endmodule

// File: tb/tb_ysyx_23060208_axi_sram_slv.sv
module tb_ysyx_23060208_axi_sram_slv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_awvalid = 0, i_wvalid = 0, i_wlast = 0, i_bready = 0;
    logic        i_arvalid = 0, i_rready = 0;
    logic [31:0] i_awaddr = 0, i_araddr = 0;
    logic [3:0]  i_awid = 0, i_arid = 0;
    logic [7:0]  i_awlen = 0, i_arlen = 0, i_wstrb = 0;
    logic [2:0]  i_awsize = 3'd3, i_arsize = 3'd3;
    logic [1:0]  i_awburst = 2'b01, i_arburst = 2'b01;
    logic [63:0] i_wdata = 0;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
    logic [1:0]  o_bresp, o_rresp;
    logic [3:0]  o_bid, o_rid;
    logic [63:0] o_rdata;

    ysyx_23060208_axi_sram_slv #(
        .BASE_ADDR(32'h8000_0000), .MEM_DEPTH(1024), .RESP_LAT(1)
    ) dut (
        .clock(clock), .reset(reset),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
        .i_awid(i_awid), .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
        .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp), .o_bid(o_bid),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .i_arid(i_arid), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata),
        .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rid(o_rid)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct packed {logic [63:0] data; logic [1:0] resp; logic [3:0] id;} rexp_t;
    typedef struct packed {logic [1:0] resp; logic [3:0] id;} bexp_t;
    rexp_t r_q[$];
    bexp_t b_q[$];
    logic [63:0] model_mem [logic [31:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [7:0] len);
        if (addr < 32'h8000_0000 || addr >= 32'h8000_2000) return 2'b11;
        if (len != 8'd0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [63:0] model_rd(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:3], 3'b000};
        return model_mem.exists(a) ? model_mem[a] : 64'd0;
    endfunction

    task automatic model_wr(input logic [31:0] addr, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        logic [31:0] a;
        a = {addr[31:3], 3'b000};
        w = model_rd(a);
        for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model_mem[a] = w;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [63:0] data, input logic [7:0] strb);
        bexp_t e;
        int n;
        e.resp = exp_resp(addr, len);
        e.id   = id;
        b_q.push_back(e);
        if (e.resp == 2'b00) model_wr(addr, data, strb);
        @(negedge clock);
        i_awvalid = 1; i_awaddr = addr; i_awid = id; i_awlen = len;
        n = 0;
        while (!o_awready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("aw_timeout", 64'(o_awready), 64'(1));
        @(negedge clock);
        i_awvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            i_wvalid = 1; i_wdata = data; i_wstrb = strb; i_wlast = (b == int'(len));
            n = 0;
            while (!o_wready && n < 50) begin @(negedge clock); n++; end
            if (n >= 50) chk("w_timeout", 64'(o_wready), 64'(1));
            @(negedge clock);
        end
        i_wvalid = 0; i_wlast = 0;
        i_bready = 1;
        n = 0;
        while (!o_bvalid && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("b_timeout", 64'(o_bvalid), 64'(1));
        e = b_q.pop_front();
        chk("bresp", 64'(o_bresp), 64'(e.resp));
        chk("bid", 64'(o_bid), 64'(e.id));
        $display("WR addr=%h id=%0d len=%0d data=%h strb=%h -> bresp=%b bid=%0d",
                 addr, id, len, data, strb, o_bresp, o_bid);
        @(negedge clock);
        i_bready = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        rexp_t e;
        int n;
        e.resp = exp_resp(addr, len);
        e.data = (e.resp == 2'b00) ? model_rd(addr) : 64'd0;
        e.id   = id;
        r_q.push_back(e);
        @(negedge clock);
        i_arvalid = 1; i_araddr = addr; i_arid = id; i_arlen = len;
        n = 0;
        while (!o_arready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("ar_timeout", 64'(o_arready), 64'(1));
        @(negedge clock);
        i_arvalid = 0;
        i_rready = 1;
        n = 0;
        while (!o_rvalid && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("r_timeout", 64'(o_rvalid), 64'(1));
        e = r_q.pop_front();
        chk("rdata", o_rdata, e.data);
        chk("rresp", 64'(o_rresp), 64'(e.resp));
        chk("rid", 64'(o_rid), 64'(e.id));
        chk("rlast", 64'(o_rlast), 64'(1));
        $display("RD addr=%h id=%0d len=%0d -> rdata=%h rresp=%b rid=%0d",
                 addr, id, len, o_rdata, o_rresp, o_rid);
        @(negedge clock);
        i_rready = 0;
    endtask

    // Write (awid=3) and read (arid=7) issued on the same cycle, RESP_LAT=1.
    task automatic concurrent(input logic [31:0] waddr, input logic [63:0] wdata,
                              input logic [31:0] raddr);
        rexp_t re;
        bexp_t be;
        re.data = model_rd(raddr);   // the read must see pre-write data
        re.resp = 2'b00;
        re.id   = 4'd7;
        r_q.push_back(re);
        be.resp = 2'b00;
        be.id   = 4'd3;
        b_q.push_back(be);
        model_wr(waddr, wdata, 8'hFF);
        @(negedge clock);
        chk("cc_awready", 64'(o_awready), 64'(1));
        chk("cc_arready", 64'(o_arready), 64'(1));
        i_awvalid = 1; i_awaddr = waddr; i_awid = 4'd3; i_awlen = 0;
        i_wvalid = 1; i_wdata = wdata; i_wstrb = 8'hFF; i_wlast = 1;
        i_arvalid = 1; i_araddr = raddr; i_arid = 4'd7; i_arlen = 0;
        @(negedge clock);   // AW and AR handshakes have happened
        i_awvalid = 0; i_arvalid = 0;
        chk("cc_rvalid_early", 64'(o_rvalid), 64'(0));
        chk("cc_bvalid_early", 64'(o_bvalid), 64'(0));
        @(negedge clock);   // W handshake has happened, the read is registered
        i_wvalid = 0; i_wlast = 0;
        chk("cc_rvalid", 64'(o_rvalid), 64'(1));
        re = r_q.pop_front();
        chk("cc_rdata", o_rdata, re.data);
        chk("cc_rid", 64'(o_rid), 64'(re.id));
        chk("cc_bvalid_w", 64'(o_bvalid), 64'(0));
        @(negedge clock);
        chk("cc_bvalid", 64'(o_bvalid), 64'(1));
        be = b_q.pop_front();
        chk("cc_bid", 64'(o_bid), 64'(be.id));
        chk("cc_bresp", 64'(o_bresp), 64'(be.resp));
        $display("CC waddr=%h raddr=%h -> rdata=%h rid=%0d bid=%0d",
                 waddr, raddr, o_rdata, o_rid, o_bid);
        i_bready = 1; i_rready = 1;
        @(negedge clock);
        i_bready = 0; i_rready = 0;
        chk("cc_bvalid_done", 64'(o_bvalid), 64'(0));
        chk("cc_rvalid_done", 64'(o_rvalid), 64'(0));
    endtask

    initial begin
        rexp_t e;
        int n;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_awready", 64'(o_awready), 64'(1));
        chk("rst_arready", 64'(o_arready), 64'(1));
        chk("rst_wready", 64'(o_wready), 64'(0));
        chk("rst_bvalid", 64'(o_bvalid), 64'(0));
        chk("rst_rvalid", 64'(o_rvalid), 64'(0));
        chk("rst_rlast", 64'(o_rlast), 64'(0));
        chk("rst_bresp", 64'(o_bresp), 64'(0));
        chk("rst_rresp", 64'(o_rresp), 64'(0));
        chk("rst_bid", 64'(o_bid), 64'(0));
        chk("rst_rid", 64'(o_rid), 64'(0));
        chk("rst_rdata", o_rdata, 64'(0));
        reset = 0;

        // Full-word write and readback
        do_write(32'h8000_0010, 4'd1, 8'd0, 64'h1122334455667788, 8'hFF);
        do_read(32'h8000_0010, 4'd2, 8'd0);
        // Partial strobe
        do_write(32'h8000_0010, 4'd1, 8'd0, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
        do_read(32'h8000_0010, 4'd2, 8'd0);
        do_write(32'h8000_0010, 4'd4, 8'd0, 64'hCCCCCCCC_DDDDDDDD, 8'hA5);
        do_read(32'h8000_0010, 4'd2, 8'd0);

        // Out-of-range accesses. 0x9000_0000 and 0x8000_2000 both alias
        // onto word 0 if the range check is broken.
        do_write(32'h8000_0000, 4'd6, 8'd0, 64'h0123456789ABCDEF, 8'hFF);
        do_read(32'h9000_0000, 4'd8, 8'd0);
        do_write(32'h9000_0000, 4'd9, 8'd0, 64'hDEADBEEFDEADBEEF, 8'hFF);
        do_read(32'h8000_0000, 4'd6, 8'd0);
        do_write(32'h8000_1FF8, 4'd10, 8'd0, 64'hFEEDFACECAFEBABE, 8'hFF);
        do_read(32'h8000_1FF8, 4'd11, 8'd0);
        do_write(32'h8000_2000, 4'd12, 8'd0, 64'h5555555555555555, 8'hFF);
        do_read(32'h8000_2000, 4'd12, 8'd0);
        do_read(32'h7FFF_FFF8, 4'd13, 8'd0);
        do_read(32'h8000_0000, 4'd6, 8'd0);

        // Burst requests: SLVERR, no array write
        do_write(32'h8000_0010, 4'd14, 8'd1, 64'h9999999999999999, 8'hFF);
        do_read(32'h8000_0010, 4'd2, 8'd0);
        do_read(32'h8000_0010, 4'd15, 8'd3);

        // R channel held off by rready=0 for 10 cycles
        e.data = model_rd(32'h8000_0010);
        e.resp = 2'b00;
        e.id   = 4'd5;
        r_q.push_back(e);
        @(negedge clock);
        i_arvalid = 1; i_araddr = 32'h8000_0010; i_arid = 4'd5; i_arlen = 0;
        @(negedge clock);
        i_arvalid = 0;
        n = 0;
        while (!o_rvalid && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("hold_r_timeout", 64'(o_rvalid), 64'(1));
        e = r_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            chk("hold_rvalid", 64'(o_rvalid), 64'(1));
            chk("hold_rdata", o_rdata, e.data);
            chk("hold_rid", 64'(o_rid), 64'(e.id));
            chk("hold_arready", 64'(o_arready), 64'(0));
            @(negedge clock);
        end
        $display("RD-HOLD addr=80000010 id=5 -> rdata=%h rid=%0d", o_rdata, o_rid);
        i_rready = 1;
        @(negedge clock);
        i_rready = 0;
        chk("hold_rvalid_done", 64'(o_rvalid), 64'(0));
        chk("hold_arready_done", 64'(o_arready), 64'(1));

        // Concurrent read and write: different words, then the same word
        concurrent(32'h8000_0020, 64'h0F0F0F0F0F0F0F0F, 32'h8000_0010);
        concurrent(32'h8000_0010, 64'h7777666655554444, 32'h8000_0010);
        do_read(32'h8000_0010, 4'd2, 8'd0);

        // Reset while the write FSM sits in W_WAIT
        @(negedge clock);
        i_awvalid = 1; i_awaddr = 32'h8000_0040; i_awid = 4'd9; i_awlen = 0;
        @(negedge clock);
        i_awvalid = 0;
        i_wvalid = 1; i_wdata = 64'h1234; i_wstrb = 8'hFF; i_wlast = 1;
        @(negedge clock);   // W handshake done: now in W_WAIT
        i_wvalid = 0; i_wlast = 0;
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("rstw_bvalid", 64'(o_bvalid), 64'(0));
        chk("rstw_awready", 64'(o_awready), 64'(1));
        chk("rstw_wready", 64'(o_wready), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("rstw_bvalid_after", 64'(o_bvalid), 64'(0));
        end
        $display("RST-ABORT write 80000040 -> bvalid=%0d awready=%0d", o_bvalid, o_awready);
        do_read(32'h8000_0010, 4'd2, 8'd0);
        do_read(32'h8000_0000, 4'd6, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
